// File: rtl/axi_master_arbiter.sv
// Single-outstanding AXI4 master shared by an IFU read port and an LSU read/write port.
// Each accepted request is captured, issued as one single-beat burst, and answered through a registered response.
module axi_master_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int IFU_ID   = 0,
  parameter int LSU_ID   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic [2:0]          lsu_size,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,

  output logic                io_master_aw_valid,
  input  logic                io_master_aw_ready,
  output logic [ADDR_W-1:0]   io_master_aw_addr,
  output logic [ID_W-1:0]     io_master_aw_id,
  output logic [7:0]          io_master_aw_len,
  output logic [2:0]          io_master_aw_size,
  output logic [1:0]          io_master_aw_burst,

  output logic                io_master_w_valid,
  input  logic                io_master_w_ready,
  output logic [DATA_W-1:0]   io_master_w_data,
  output logic [DATA_W/8-1:0] io_master_w_strb,
  output logic                io_master_w_last,

  input  logic                io_master_b_valid,
  output logic                io_master_b_ready,
  input  logic [1:0]          io_master_b_resp,
  input  logic [ID_W-1:0]     io_master_b_id,

  output logic                io_master_ar_valid,
  input  logic                io_master_ar_ready,
  output logic [ADDR_W-1:0]   io_master_ar_addr,
  output logic [ID_W-1:0]     io_master_ar_id,
  output logic [7:0]          io_master_ar_len,
  output logic [2:0]          io_master_ar_size,
  output logic [1:0]          io_master_ar_burst,

  input  logic                io_master_r_valid,
  output logic                io_master_r_ready,
  input  logic [DATA_W-1:0]   io_master_r_data,
  input  logic [1:0]          io_master_r_resp,
  input  logic                io_master_r_last,
  input  logic [ID_W-1:0]     io_master_r_id
);

  localparam int              STRB_W     = DATA_W / 8;
  localparam logic [2:0]      FULL_SIZE  = (DATA_W == 64) ? 3'd3 : 3'd2;
  localparam logic [ID_W-1:0] IFU_AXI_ID = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] LSU_AXI_ID = ID_W'(LSU_ID);
  localparam bit              LSU_FIXED  = (ARB_MODE == 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t              state_reg;
  logic                owner_lsu_reg;
  logic                last_lsu_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic [2:0]          size_reg;
  logic                arvalid_reg;
  logic                awvalid_reg;
  logic                wvalid_reg;
  logic                aw_done_reg;
  logic                w_done_reg;
  logic                bready_reg;
  logic                rready_reg;
  logic                ifu_resp_valid_reg;
  logic                lsu_resp_valid_reg;
  logic                ifu_err_reg;
  logic                lsu_err_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic                grant_lsu;
  logic                grant_ifu;
  logic                accept_open;
  logic [ID_W-1:0]     owner_id;
  logic                r_err;
  logic                b_err;
  logic                aw_hs;
  logic                w_hs;
  logic                aw_fin;
  logic                w_fin;
  logic                resp_hs;

  // last_lsu_reg = 0 means the IFU was granted last, so the LSU wins the next tie.
  assign grant_lsu   = lsu_req_valid && (LSU_FIXED || !ifu_req_valid || !last_lsu_reg);
  assign grant_ifu   = ifu_req_valid && !grant_lsu;
  assign accept_open = (state_reg == IDLE) && !reset;

  assign ifu_req_ready = accept_open && grant_ifu;
  assign lsu_req_ready = accept_open && grant_lsu;

  assign owner_id = owner_lsu_reg ? LSU_AXI_ID : IFU_AXI_ID;
  assign r_err    = (io_master_r_resp != 2'b00) || (io_master_r_id != owner_id) || !io_master_r_last;
  assign b_err    = (io_master_b_resp != 2'b00) || (io_master_b_id != LSU_AXI_ID);

  assign aw_hs   = awvalid_reg && io_master_aw_ready;
  assign w_hs    = wvalid_reg && io_master_w_ready;
  assign aw_fin  = aw_done_reg || aw_hs;
  assign w_fin   = w_done_reg || w_hs;
  assign resp_hs = (ifu_resp_valid_reg && ifu_resp_ready) || (lsu_resp_valid_reg && lsu_resp_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= IDLE;
      owner_lsu_reg      <= 1'b0;
      last_lsu_reg       <= 1'b0;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      wstrb_reg          <= '0;
      size_reg           <= 3'd0;
      arvalid_reg        <= 1'b0;
      awvalid_reg        <= 1'b0;
      wvalid_reg         <= 1'b0;
      aw_done_reg        <= 1'b0;
      w_done_reg         <= 1'b0;
      bready_reg         <= 1'b0;
      rready_reg         <= 1'b0;
      ifu_resp_valid_reg <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      ifu_err_reg        <= 1'b0;
      lsu_err_reg        <= 1'b0;
      rdata_reg          <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ifu_req_ready) begin
            owner_lsu_reg <= 1'b0;
            last_lsu_reg  <= 1'b0;
            addr_reg      <= ifu_addr;
            size_reg      <= FULL_SIZE;
            arvalid_reg   <= 1'b1;
            state_reg     <= RD_AR;
          end else if (lsu_req_ready) begin
            owner_lsu_reg <= 1'b1;
            last_lsu_reg  <= 1'b1;
            addr_reg      <= lsu_addr;
            wdata_reg     <= lsu_wdata;
            wstrb_reg     <= lsu_wstrb;
            size_reg      <= lsu_size;
            if (lsu_wen) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              state_reg   <= WR_AW_W;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_AR;
            end
          end
        end

        RD_AR: begin
          if (io_master_ar_ready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_R;
          end
        end

        RD_R: begin
          if (io_master_r_valid) begin
            rready_reg <= 1'b0;
            rdata_reg  <= io_master_r_data;
            if (owner_lsu_reg) begin
              lsu_resp_valid_reg <= 1'b1;
              lsu_err_reg        <= r_err;
            end else begin
              ifu_resp_valid_reg <= 1'b1;
              ifu_err_reg        <= r_err;
            end
            state_reg <= RESP;
          end
        end

        // AW and W complete independently; the flags remember whichever finished first.
        WR_AW_W: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            bready_reg  <= 1'b1;
            state_reg   <= WR_B;
          end
        end

        WR_B: begin
          if (io_master_b_valid) begin
            bready_reg         <= 1'b0;
            rdata_reg          <= '0;
            lsu_resp_valid_reg <= 1'b1;
            lsu_err_reg        <= b_err;
            state_reg          <= RESP;
          end
        end

        RESP: begin
          if (resp_hs) begin
            ifu_resp_valid_reg <= 1'b0;
            lsu_resp_valid_reg <= 1'b0;
            state_reg          <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ifu_resp_valid = ifu_resp_valid_reg;
  assign ifu_rdata      = rdata_reg;
  assign ifu_resp_err   = ifu_err_reg;
  assign lsu_resp_valid = lsu_resp_valid_reg;
  assign lsu_rdata      = rdata_reg;
  assign lsu_resp_err   = lsu_err_reg;

  assign io_master_aw_valid = awvalid_reg;
  assign io_master_aw_addr  = addr_reg;
  assign io_master_aw_id    = LSU_AXI_ID;
  assign io_master_aw_len   = 8'd0;
  assign io_master_aw_size  = size_reg;
  assign io_master_aw_burst = 2'b01;

  assign io_master_w_valid = wvalid_reg;
  assign io_master_w_data  = wdata_reg;
  assign io_master_w_strb  = wstrb_reg;
  assign io_master_w_last  = wvalid_reg;

  assign io_master_b_ready = bready_reg;

  assign io_master_ar_valid = arvalid_reg;
  assign io_master_ar_addr  = addr_reg;
  assign io_master_ar_id    = owner_id;
  assign io_master_ar_len   = 8'd0;
  assign io_master_ar_size  = size_reg;
  assign io_master_ar_burst = 2'b01;

  assign io_master_r_ready = rready_reg;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench: a table of single transactions against a scripted slave, plus arbitration and mid-write reset sequences.
module tb_axi_master_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0, ifu_resp_err;
  logic [31:0] ifu_addr = '0, ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0, lsu_resp_err;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [3:0]  lsu_wstrb = '0;
  logic [2:0]  lsu_size = '0;

  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid = '0;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
  logic [31:0] araddr, rdata = '0;
  logic [3:0]  arid, rid = '0;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp = '0;

  // Second instance (fixed LSU priority) shares the slave side and response readies.
  logic        m1_ifu_req_valid = 1'b0, m1_lsu_req_valid = 1'b0;
  logic        m1_ifu_req_ready, m1_ifu_resp_valid, m1_ifu_resp_err;
  logic        m1_lsu_req_ready, m1_lsu_resp_valid, m1_lsu_resp_err;
  logic [31:0] m1_ifu_rdata, m1_lsu_rdata, m1_awaddr, m1_wdata, m1_araddr;
  logic        m1_awvalid, m1_wvalid, m1_wlast, m1_bready, m1_arvalid, m1_rready;
  logic [3:0]  m1_awid, m1_wstrb, m1_arid;
  logic [7:0]  m1_awlen, m1_arlen;
  logic [2:0]  m1_awsize, m1_arsize;
  logic [1:0]  m1_awburst, m1_arburst;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axi_master_arbiter #(.ARB_MODE(0)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .io_master_aw_valid(awvalid), .io_master_aw_ready(awready), .io_master_aw_addr(awaddr), .io_master_aw_id(awid),
    .io_master_aw_len(awlen), .io_master_aw_size(awsize), .io_master_aw_burst(awburst),
    .io_master_w_valid(wvalid), .io_master_w_ready(wready), .io_master_w_data(wdata), .io_master_w_strb(wstrb),
    .io_master_w_last(wlast),
    .io_master_b_valid(bvalid), .io_master_b_ready(bready), .io_master_b_resp(bresp), .io_master_b_id(bid),
    .io_master_ar_valid(arvalid), .io_master_ar_ready(arready), .io_master_ar_addr(araddr), .io_master_ar_id(arid),
    .io_master_ar_len(arlen), .io_master_ar_size(arsize), .io_master_ar_burst(arburst),
    .io_master_r_valid(rvalid), .io_master_r_ready(rready), .io_master_r_data(rdata), .io_master_r_resp(rresp),
    .io_master_r_last(rlast), .io_master_r_id(rid)
  );

  axi_master_arbiter #(.ARB_MODE(1)) dut_fixed (
    .clock(clock), .reset(reset),
    .ifu_req_valid(m1_ifu_req_valid), .ifu_req_ready(m1_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(m1_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(m1_ifu_rdata), .ifu_resp_err(m1_ifu_resp_err),
    .lsu_req_valid(m1_lsu_req_valid), .lsu_req_ready(m1_lsu_req_ready), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
    .lsu_resp_valid(m1_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(m1_lsu_rdata), .lsu_resp_err(m1_lsu_resp_err),
    .io_master_aw_valid(m1_awvalid), .io_master_aw_ready(awready), .io_master_aw_addr(m1_awaddr), .io_master_aw_id(m1_awid),
    .io_master_aw_len(m1_awlen), .io_master_aw_size(m1_awsize), .io_master_aw_burst(m1_awburst),
    .io_master_w_valid(m1_wvalid), .io_master_w_ready(wready), .io_master_w_data(m1_wdata), .io_master_w_strb(m1_wstrb),
    .io_master_w_last(m1_wlast),
    .io_master_b_valid(bvalid), .io_master_b_ready(m1_bready), .io_master_b_resp(bresp), .io_master_b_id(bid),
    .io_master_ar_valid(m1_arvalid), .io_master_ar_ready(arready), .io_master_ar_addr(m1_araddr), .io_master_ar_id(m1_arid),
    .io_master_ar_len(m1_arlen), .io_master_ar_size(m1_arsize), .io_master_ar_burst(m1_arburst),
    .io_master_r_valid(rvalid), .io_master_r_ready(m1_rready), .io_master_r_data(rdata), .io_master_r_resp(rresp),
    .io_master_r_last(rlast), .io_master_r_id(rid)
  );

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [1:0]  resp;
    logic [3:0]  id;
    bit          last;
    logic [31:0] sdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    v        = vt[i];
    exp_id   = v.lsu ? 4'd1 : 4'd0;
    exp_size = v.lsu ? v.size : 3'd2;
    tick();
    if (!v.lsu) begin
      ifu_req_valid = 1'b1;
      ifu_addr      = v.addr;
    end else begin
      lsu_req_valid = 1'b1;
      lsu_wen       = v.wen;
      lsu_addr      = v.addr;
      lsu_wdata     = v.wdata;
      lsu_wstrb     = v.wstrb;
      lsu_size      = v.size;
    end
    @(negedge clock);
    check("req_ready", 64'(v.lsu ? lsu_req_ready : ifu_req_ready), 64'(1));
    check("no_valid_before_accept", 64'({arvalid, awvalid, wvalid}), 64'(0));
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clock);
    if (!v.wen) begin
      check("ar_fields", {29'(0), arvalid, araddr, arid, arsize},
            {29'(0), 1'b1, v.addr, exp_id, exp_size});
      check("ar_len_burst", 64'({arlen, arburst}), 64'({8'd0, 2'b01}));
      check("read_no_aw_w", 64'({awvalid, wvalid}), 64'(0));
      tick();
      @(negedge clock);
      check("arvalid_hold", 64'(arvalid), 64'(1));
      arready = 1'b1;
      tick();
      arready = 1'b0;
      @(negedge clock);
      check("ar_done_rready", 64'({arvalid, rready}), 64'(2'b01));
      repeat (2) tick();
      rvalid = 1'b1; rdata = v.sdata; rresp = v.resp; rid = v.id; rlast = v.last;
      @(negedge clock);
      check("no_early_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      tick();
      rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
    end else begin
      check("aw_fields", {28'(0), awvalid, awaddr, awid, awsize},
            {28'(0), 1'b1, v.addr, 4'd1, v.size});
      check("w_fields", {27'(0), wvalid, wlast, wdata, wstrb}, {27'(0), 1'b1, 1'b1, v.wdata, v.wstrb});
      check("aw_len_burst", 64'({awlen, awburst}), 64'({8'd0, 2'b01}));
      check("write_no_ar", 64'(arvalid), 64'(0));
      wready = 1'b1;
      tick();
      wready = 1'b0;
      @(negedge clock);
      check("w_first", 64'({awvalid, wvalid, wlast, bready}), 64'(4'b1000));
      tick();
      awready = 1'b1;
      tick();
      awready = 1'b0;
      @(negedge clock);
      check("aw_done_bready", 64'({awvalid, wvalid, bready}), 64'(3'b001));
      tick();
      @(negedge clock);
      check("no_resp_before_b", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      tick();
      bvalid = 1'b1; bresp = v.resp; bid = v.id;
      @(negedge clock);
      check("no_early_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      tick();
      bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    end
    @(negedge clock);
    check("resp", {30'(0), v.lsu ? lsu_resp_valid : ifu_resp_valid, v.lsu ? lsu_resp_err : ifu_resp_err,
                   v.lsu ? lsu_rdata : ifu_rdata},
          {30'(0), 1'b1, v.exp_err, v.exp_rdata});
    check("other_resp_idle", 64'(v.lsu ? ifu_resp_valid : lsu_resp_valid), 64'(0));
    check("resp_readies_low", 64'({rready, bready, arvalid, awvalid, wvalid}), 64'(0));
    tick();
    tick();
    @(negedge clock);
    check("resp_hold", {31'(0), v.lsu ? lsu_resp_valid : ifu_resp_valid, v.lsu ? lsu_rdata : ifu_rdata},
          {31'(0), 1'b1, v.exp_rdata});
    if (v.lsu) lsu_resp_ready = 1'b1;
    else       ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
    @(negedge clock);
    check("resp_drop", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
    $display("txn %0d %s %s addr=%h rdata=%h err=%0d", i, v.lsu ? "LSU" : "IFU", v.wen ? "WR" : "RD",
             v.addr, v.lsu ? lsu_rdata : ifu_rdata, v.lsu ? lsu_resp_err : ifu_resp_err);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int ip0, lp0, ip1, lp1, n0, n1;
    bit g0[8];
    bit g1[8];
    bit exp0[8];
    bit exp1[8];

    vt[0] = '{lsu:0, wen:0, addr:32'h8000_0000, wdata:0, wstrb:0, size:0, resp:2'b00, id:4'd0, last:1,
              sdata:32'h0000_0413, exp_rdata:32'h0000_0413, exp_err:0};
    vt[1] = '{lsu:1, wen:0, addr:32'h2000_0010, wdata:0, wstrb:0, size:3'd2, resp:2'b00, id:4'd1, last:1,
              sdata:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D, exp_err:0};
    vt[2] = '{lsu:1, wen:0, addr:32'h2000_0020, wdata:0, wstrb:0, size:3'd1, resp:2'b10, id:4'd1, last:1,
              sdata:32'h1234_5678, exp_rdata:32'h1234_5678, exp_err:1};
    vt[3] = '{lsu:0, wen:0, addr:32'h8000_0004, wdata:0, wstrb:0, size:0, resp:2'b00, id:4'd3, last:1,
              sdata:32'h0010_0073, exp_rdata:32'h0010_0073, exp_err:1};
    vt[4] = '{lsu:1, wen:1, addr:32'h1000_0004, wdata:32'hDEAD_BEEF, wstrb:4'b0011, size:3'd2, resp:2'b00, id:4'd1,
              last:1, sdata:0, exp_rdata:0, exp_err:0};
    vt[5] = '{lsu:1, wen:1, addr:32'h1000_0008, wdata:32'hA5A5_A5A5, wstrb:4'b1111, size:3'd2, resp:2'b11, id:4'd1,
              last:1, sdata:0, exp_rdata:0, exp_err:1};
    vt[6] = '{lsu:0, wen:0, addr:32'h8000_0008, wdata:0, wstrb:0, size:0, resp:2'b00, id:4'd0, last:0,
              sdata:32'h1111_1111, exp_rdata:32'h1111_1111, exp_err:1};
    vt[7] = '{lsu:1, wen:1, addr:32'h1000_000C, wdata:32'h0102_0304, wstrb:4'b0100, size:3'd0, resp:2'b00, id:4'd2,
              last:1, sdata:0, exp_rdata:0, exp_err:1};

    repeat (3) tick();
    @(negedge clock);
    check("in_reset_outputs", 64'({ifu_req_ready, lsu_req_ready, arvalid, awvalid, wvalid, bready, rready,
                                   ifu_resp_valid, lsu_resp_valid}), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    check("reset_valids", 64'({arvalid, awvalid, wvalid, bready, rready, ifu_resp_valid, lsu_resp_valid}), 64'(0));
    check("reset_resp_regs", 64'({ifu_resp_err, lsu_resp_err, |ifu_rdata, |lsu_rdata}), 64'(0));
    check("reset_fixed_inst", 64'({m1_ifu_req_ready, m1_ifu_resp_valid, m1_ifu_resp_err, |m1_ifu_rdata,
                                   m1_lsu_req_ready, m1_lsu_resp_valid, m1_lsu_resp_err, |m1_lsu_rdata,
                                   m1_awvalid, |m1_awaddr, m1_awid != 4'd1, |m1_awlen, |m1_awsize,
                                   m1_awburst != 2'b01, m1_wvalid, |m1_wdata, |m1_wstrb, m1_wlast, m1_bready,
                                   m1_arvalid, |m1_araddr, |m1_arid, |m1_arlen, |m1_arsize,
                                   m1_arburst != 2'b01, m1_rready}), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(i);

    // Tie-break: both requesters hold valid until four grants each; slave answers immediately.
    reset_pulse();
    arready = 1'b1; awready = 1'b1; wready = 1'b1; rvalid = 1'b1; bvalid = 1'b1; rlast = 1'b1;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1; lsu_wen = 1'b0;
    ip0 = 4; lp0 = 4; ip1 = 4; lp1 = 4; n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      exp0[k] = (k % 2 == 0);
      exp1[k] = (k < 4);
      g0[k] = 1'b0;
      g1[k] = 1'b0;
    end
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; m1_ifu_req_valid = 1'b1; m1_lsu_req_valid = 1'b1;
    for (int c = 0; c < 300 && (n0 < 8 || n1 < 8); c++) begin
      @(negedge clock);
      if (ifu_req_valid && ifu_req_ready && n0 < 8) begin g0[n0] = 1'b0; n0++; ip0--; end
      if (lsu_req_valid && lsu_req_ready && n0 < 8) begin g0[n0] = 1'b1; n0++; lp0--; end
      if (m1_ifu_req_valid && m1_ifu_req_ready && n1 < 8) begin g1[n1] = 1'b0; n1++; ip1--; end
      if (m1_lsu_req_valid && m1_lsu_req_ready && n1 < 8) begin g1[n1] = 1'b1; n1++; lp1--; end
      tick();
      ifu_req_valid    = (ip0 > 0);
      lsu_req_valid    = (lp0 > 0);
      m1_ifu_req_valid = (ip1 > 0);
      m1_lsu_req_valid = (lp1 > 0);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; m1_ifu_req_valid = 1'b0; m1_lsu_req_valid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0; rlast = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    check("arb_rr_grant_count", 64'(n0), 64'(8));
    check("arb_fixed_grant_count", 64'(n1), 64'(8));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("arb_rr_grant%0d", k), 64'(g0[k]), 64'(exp0[k]));
      check($sformatf("arb_fixed_grant%0d", k), 64'(g1[k]), 64'(exp1[k]));
      $display("grant %0d rr=%s fixed=%s", k, g0[k] ? "LSU" : "IFU", g1[k] ? "LSU" : "IFU");
    end

    // Reset while waiting for B: the write is dropped and the next fetch runs cleanly.
    reset_pulse();
    tick();
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h3000_0000; lsu_wdata = 32'h0000_0055;
    lsu_wstrb = 4'b1111; lsu_size = 3'd2; awready = 1'b1; wready = 1'b1;
    @(negedge clock);
    check("wrb_req_ready", 64'(lsu_req_ready), 64'(1));
    tick();
    lsu_req_valid = 1'b0;
    @(negedge clock);
    check("wrb_aw_w_together", 64'({awvalid, wvalid}), 64'(2'b11));
    tick();
    awready = 1'b0; wready = 1'b0;
    @(negedge clock);
    check("wrb_in_wr_b", 64'({awvalid, wvalid, bready, lsu_resp_valid}), 64'(4'b0010));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("wrb_after_reset", 64'({arvalid, awvalid, wvalid, bready, rready, ifu_resp_valid, lsu_resp_valid,
                                  ifu_req_ready, lsu_req_ready}), 64'(0));
    $display("txn reset-in-WR_B dropped write addr=%h", lsu_addr);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
